// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock sequencer:
// state codes, special key codes and a digit test.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_OPEN   = 3'd3,
        ST_NEW    = 3'd4,
        ST_LOCKED = 3'd5
    } state_e;

    localparam logic [3:0] KEY_ENTER = 4'hF;
    localparam logic [3:0] KEY_BACK  = 4'hE;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/pwd_entry_buf.sv
// Nibble entry buffer: newest digit enters the low nibble.
// Ports: push/pop/clr + din in; dout, cnt, full, empty out.
module pwd_entry_buf #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                clr,
    input  logic [3:0]          din,
    output logic [DIGITS*4-1:0] dout,
    output logic [2:0]          cnt,
    output logic                full,
    output logic                empty
);

    localparam int W = DIGITS * 4;

    logic [W-1:0] buf_q, buf_d;
    logic [2:0]   cnt_q, cnt_d;

    assign full  = (cnt_q == 3'(DIGITS));
    assign empty = (cnt_q == 3'd0);
    assign dout  = buf_q;
    assign cnt   = cnt_q;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (clr) begin
            buf_d = '0;
            cnt_d = 3'd0;
        end else if (push && !full) begin
            buf_d = {buf_q[W-5:0], din};
            cnt_d = cnt_q + 3'd1;
        end else if (pop && !empty) begin
            buf_d = buf_q >> 4;
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= 3'd0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lock_seq_ctrl.sv
// Keypad lock sequencer: entry, check, lockout, unlock hold, pwd change.
// In: clk, rst_n, key_valid, key_val, lock_done.
// Out: unlock, lock_start, err, pwd_changed, state_code, digit_cnt, entry_pwd.
module lock_seq_ctrl
    import lock_pkg::*;
#(
    parameter int                  DIGITS        = 4,
    parameter int                  MAX_TRIES     = 3,
    parameter logic [DIGITS*4-1:0] INIT_PWD      = '0,
    parameter int unsigned         UNLOCK_CYCLES = 250000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    input  logic [3:0]          key_val,
    input  logic                lock_done,
    output logic                unlock,
    output logic                lock_start,
    output logic                err,
    output logic                pwd_changed,
    output logic [2:0]          state_code,
    output logic [2:0]          digit_cnt,
    output logic [DIGITS*4-1:0] entry_pwd
);

    localparam int W  = DIGITS * 4;
    localparam int HW = $clog2(UNLOCK_CYCLES + 1);
    localparam logic [2:0] LAST_TRY = 3'(MAX_TRIES - 1);

    state_e        state_q, state_d;
    logic [2:0]    fail_q, fail_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [W-1:0]  stored_q, stored_d;
    logic          unlock_q, unlock_d;
    logic          lock_start_q, lock_start_d;
    logic          err_q, err_d;
    logic          chg_q, chg_d;

    logic          push, pop, clr, full, empty;
    logic          k_dig, k_ent, k_back;
    logic [W-1:0]  buf_val;

    assign k_dig  = key_valid && is_digit(key_val);
    assign k_ent  = key_valid && (key_val == KEY_ENTER);
    assign k_back = key_valid && (key_val == KEY_BACK);

    pwd_entry_buf #(.DIGITS(DIGITS)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clr   (clr),
        .din   (key_val),
        .dout  (buf_val),
        .cnt   (digit_cnt),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d      = state_q;
        fail_d       = fail_q;
        hold_d       = hold_q;
        stored_d     = stored_q;
        err_d        = 1'b0;
        lock_start_d = 1'b0;
        chg_d        = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        clr          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (k_ent) begin
                    clr     = 1'b1;
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY, ST_NEW: begin
                if (k_dig) begin
                    push = 1'b1;
                end else if (k_back) begin
                    if (empty) state_d = ST_IDLE;
                    else       pop     = 1'b1;
                end else if (k_ent) begin
                    if (!full) begin
                        err_d = 1'b1;
                    end else if (state_q == ST_ENTRY) begin
                        state_d = ST_CHECK;
                    end else begin
                        stored_d = buf_val;
                        chg_d    = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_CHECK: begin
                if (buf_val == stored_q) begin
                    fail_d  = 3'd0;
                    hold_d  = HW'(UNLOCK_CYCLES);
                    state_d = ST_OPEN;
                end else if (fail_q == LAST_TRY) begin
                    err_d        = 1'b1;
                    lock_start_d = 1'b1;
                    fail_d       = 3'd0;
                    state_d      = ST_LOCKED;
                end else begin
                    err_d   = 1'b1;
                    fail_d  = fail_q + 3'd1;
                    clr     = 1'b1;
                    state_d = ST_ENTRY;
                end
            end
            ST_OPEN: begin
                // final count beats a simultaneous enter key
                if (hold_q <= HW'(1)) begin
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else if (k_ent) begin
                    hold_d  = '0;
                    clr     = 1'b1;
                    state_d = ST_NEW;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            ST_LOCKED: begin
                if (lock_done) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        unlock_d = (state_d == ST_OPEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fail_q       <= 3'd0;
            hold_q       <= '0;
            stored_q     <= INIT_PWD;
            unlock_q     <= 1'b0;
            lock_start_q <= 1'b0;
            err_q        <= 1'b0;
            chg_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_q       <= fail_d;
            hold_q       <= hold_d;
            stored_q     <= stored_d;
            unlock_q     <= unlock_d;
            lock_start_q <= lock_start_d;
            err_q        <= err_d;
            chg_q        <= chg_d;
        end
    end

    assign unlock      = unlock_q;
    assign lock_start  = lock_start_q;
    assign err         = err_q;
    assign pwd_changed = chg_q;
    assign state_code  = state_q;
    assign entry_pwd   = buf_val;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Bench for lock_seq_ctrl: directed scenarios plus random keys,
// every cycle compared against a queue-based reference model.
module tb_lock_seq_ctrl;

    localparam int NDIG = 4;
    localparam int MAXT = 3;
    localparam int HOLD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_val = 4'h0;
    logic        lock_done = 1'b0;
    logic        unlock, lock_start, err, pwd_changed;
    logic [2:0]  state_code, digit_cnt;
    logic [15:0] entry_pwd;

    lock_seq_ctrl #(
        .DIGITS(NDIG), .MAX_TRIES(MAXT),
        .INIT_PWD(16'h0000), .UNLOCK_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_val(key_val),
        .lock_done(lock_done),
        .unlock(unlock), .lock_start(lock_start),
        .err(err), .pwd_changed(pwd_changed),
        .state_code(state_code), .digit_cnt(digit_cnt),
        .entry_pwd(entry_pwd)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      tag, obs, exp, $time);
    endtask

    // reference model: states as plain ints, buffer as a digit queue
    int          m_st;
    logic [3:0]  m_q[$];
    logic [15:0] m_pwd;
    int          m_fail, m_hold;
    bit          m_err, m_ls, m_chg;

    function automatic logic [15:0] m_entry();
        logic [15:0] v = 16'h0;
        foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
        return v;
    endfunction

    task automatic m_reset();
        m_st = 0; m_q = {}; m_pwd = 16'h0000;
        m_fail = 0; m_hold = 0;
        m_err = 0; m_ls = 0; m_chg = 0;
    endtask

    task automatic m_step(input bit kv, input int k, input bit ld);
        m_err = 0; m_ls = 0; m_chg = 0;
        case (m_st)
            0: if (kv && k == 15) begin m_q = {}; m_st = 1; end
            1, 4: if (kv) begin
                if (k <= 9) begin
                    if (m_q.size() < NDIG) m_q.push_back(4'(k));
                end else if (k == 14) begin
                    if (m_q.size() == 0) m_st = 0;
                    else void'(m_q.pop_back());
                end else if (k == 15) begin
                    if (m_q.size() < NDIG) m_err = 1;
                    else if (m_st == 1) m_st = 2;
                    else begin m_pwd = m_entry(); m_chg = 1; m_st = 0; end
                end
            end
            2: begin
                if (m_entry() == m_pwd) begin
                    m_st = 3; m_fail = 0; m_hold = HOLD;
                end else if (m_fail + 1 == MAXT) begin
                    m_err = 1; m_ls = 1; m_fail = 0; m_st = 5;
                end else begin
                    m_err = 1; m_fail++; m_q = {}; m_st = 1;
                end
            end
            3: begin
                m_hold--;
                if (m_hold == 0) m_st = 0;
                else if (kv && k == 15) begin m_q = {}; m_st = 4; end
            end
            5: if (ld) m_st = 0;
            default: m_st = 0;
        endcase
    endtask

    task automatic compare_all();
        chk("state", 32'(state_code), 32'(m_st));
        chk("unlock", 32'(unlock), 32'(m_st == 3));
        chk("err", 32'(err), 32'(m_err));
        chk("lock_start", 32'(lock_start), 32'(m_ls));
        chk("pwd_changed", 32'(pwd_changed), 32'(m_chg));
        chk("digit_cnt", 32'(digit_cnt), 32'(m_q.size()));
        chk("entry_pwd", 32'(entry_pwd), 32'(m_entry()));
    endtask

    task automatic step(input bit kv, input logic [3:0] k, input bit ld);
        key_valid = kv; key_val = k; lock_done = ld;
        @(posedge clk);
        m_step(kv, int'(k), ld);
        #1;
        compare_all();
        key_valid = 1'b0; lock_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'h0, 0);
    endtask

    task automatic press(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c = s[i];
            logic [3:0] k;
            k = (c >= 48 && c <= 57) ? 4'(c - 48) : 4'(c - 55);
            step(1, k, 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int cnt_unlock, cnt_err;

    initial begin
        m_reset();
        #2;
        do_reset();

        // 1: open with initial password, hold for HOLD cycles
        press("F0000F");
        cnt_unlock = 0; cnt_err = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, 4'h0, 0);
            cnt_unlock += int'(unlock);
            cnt_err += int'(err);
        end
        chk("t1_hold_len", 32'(cnt_unlock), 32'(HOLD));
        chk("t1_no_err", 32'(cnt_err), 32'd0);
        chk("t1_idle", 32'(state_code), 32'd0);

        // 2: three wrong tries -> lockout
        press("F1234F"); idle(2);
        press("F1234F"); idle(2);
        press("F1234F"); idle(2);
        chk("t2_locked", 32'(state_code), 32'd5);
        press("F0000F");
        chk("t2_still_locked", 32'(state_code), 32'd5);
        step(1, 4'hF, 1);
        chk("t2_released", 32'(state_code), 32'd0);
        idle(1);

        // 3: backspace editing, short enter, abandon
        press("F12E3");
        chk("t3_entry", 32'(entry_pwd), 32'h0013);
        chk("t3_cnt", 32'(digit_cnt), 32'd2);
        press("F");
        chk("t3_short_err", 32'(err), 32'd1);
        chk("t3_stay", 32'(state_code), 32'd1);
        press("EEE");
        chk("t3_idle", 32'(state_code), 32'd0);

        // 4: no wrap past DIGITS
        press("F56789");
        chk("t4_entry", 32'(entry_pwd), 32'h5678);
        press("EEEEE");

        // 5: change password, then use it
        press("F0000F"); idle(2);
        press("F9876F");
        chk("t5_changed", 32'(pwd_changed), 32'd1);
        press("F9876F"); idle(2);
        chk("t5_open", 32'(unlock), 32'd1);
        idle(20);
        press("F0000F");
        idle(1);
        chk("t5_old_err", 32'(err), 32'd1);
        press("E");

        // 6a: enter on final hold count -> IDLE
        press("F9876F"); idle(1);
        for (int i = 0; i < 40 && !(m_st == 3 && m_hold == 1); i++)
            idle(1);
        chk("t6_at_final", 32'(m_hold), 32'd1);
        press("F");
        chk("t6_timeout_wins", 32'(state_code), 32'd0);

        // 6b: reset during NEW_ENTRY restores INIT_PWD
        press("F9876F"); idle(2);
        press("F12");
        do_reset();
        chk("t6_rst_state", 32'(state_code), 32'd0);
        press("F0000F"); idle(2);
        chk("t6_init_pwd", 32'(unlock), 32'd1);
        idle(20);

        // random traffic, biased toward short digit alphabets
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [3:0] k;
            r = $urandom_range(0, 99);
            if (r < 30) k = 4'hF;
            else if (r < 75) k = 4'($urandom_range(0, 1));
            else if (r < 88) k = 4'hE;
            else k = 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) < 60, k,
                 $urandom_range(0, 11) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
